// File: rtl/glb_stream_arbiter.sv
// Round-robin arbiter sharing one GLB write stream among NUM_SRC tile sources.
// Optional per-source transfer counters when GLB_ARB_STATS_EN is defined.

module glb_arb_src_lane (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_flush,
  input  logic        i_done,
`ifdef GLB_ARB_STATS_EN
  input  logic        i_xfer,
  output logic [15:0] o_stat,
`endif
  output logic        o_done_q
);

  logic r_done_q;

  // Sticky completion flag; only flush or reset re-arms the source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_done_q <= 1'b0;
    else if (i_flush) r_done_q <= 1'b0;
    else if (i_done)  r_done_q <= 1'b1;
  end

  assign o_done_q = r_done_q;

`ifdef GLB_ARB_STATS_EN
  logic [15:0] r_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_stat <= '0;
    else if (i_flush)                      r_stat <= '0;
    else if (i_xfer && r_stat != 16'hFFFF) r_stat <= r_stat + 16'd1;
  end

  assign o_stat = r_stat;
`endif

endmodule

module glb_stream_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_SRC-1:0]          src_en,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC-1:0]          src_done,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_SRC)-1:0]  out_src_id,
`ifdef GLB_ARB_STATS_EN
  output logic [NUM_SRC*16-1:0]       stat_count,
`endif
  output logic                        all_done
);

  localparam int IDW = $clog2(NUM_SRC);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  localparam logic [IDW:0]   NSRC_W     = (IDW+1)'(NUM_SRC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                    r_state;
  logic [IDW-1:0]                r_rr_ptr;
  logic [IDW-1:0]                r_grant;
  logic [BCW-1:0]                r_burst;
  logic                          r_all_done;

  logic [NUM_SRC-1:0][DATA_W-1:0] w_src_data;
  logic [NUM_SRC-1:0]            w_done_q;
  logic [NUM_SRC-1:0]            w_elig;
  logic                          w_all_fin;
  logic                          w_pick_vld;
  logic [IDW-1:0]                w_pick;
  logic [IDW:0]                  w_sum;
  logic                          w_gnt_act;
  logic                          w_xfer;
  logic                          w_last;
  logic                          w_release;

  assign w_src_data = src_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lane
      glb_arb_src_lane u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (flush),
        .i_done   (src_done[gi]),
`ifdef GLB_ARB_STATS_EN
        .i_xfer   (w_xfer && (r_grant == IDW'(gi))),
        .o_stat   (stat_count[gi*16 +: 16]),
`endif
        .o_done_q (w_done_q[gi])
      );
    end
  endgenerate

  // A source raising done this cycle is already excluded from arbitration.
  assign w_elig    = src_en & src_valid & ~w_done_q & ~src_done;
  assign w_all_fin = &(w_done_q | ~src_en);

  // First eligible source searching upward from rr_ptr+1, wrapping at NUM_SRC.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_sum      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= NSRC_W) w_sum = w_sum - NSRC_W;
      if (!w_pick_vld && w_elig[w_sum[IDW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_sum[IDW-1:0];
      end
    end
  end

  assign w_gnt_act = (r_state == ST_GRANT) && !flush;
  assign out_valid = w_gnt_act && src_valid[r_grant];
  assign out_data  = w_gnt_act ? w_src_data[r_grant] : '0;
  assign out_src_id = r_grant;
  assign all_done   = r_all_done;

  always_comb begin
    src_ready = '0;
    if (w_gnt_act) src_ready[r_grant] = out_ready;
  end

  assign w_xfer    = out_valid && out_ready;
  assign w_last    = w_xfer && (r_burst == BURST_LAST);
  assign w_release = w_last || src_done[r_grant] || !src_valid[r_grant] || !src_en[r_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_burst    <= '0;
      r_all_done <= 1'b0;
    end else if (flush) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_burst    <= '0;
      r_all_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_all_fin) begin
            r_state <= ST_DONE;
          end else if (w_pick_vld) begin
            r_grant <= w_pick;
            r_burst <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_xfer) r_burst <= r_burst + 1'b1;
          if (w_release) begin
            r_rr_ptr <= r_grant;
            r_state  <= ST_IDLE;
          end
        end
        ST_DONE: r_all_done <= 1'b1;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_stream_arbiter.sv
// Scoreboard bench for glb_stream_arbiter: per-source expected queues, cycle-level checks.
module tb_glb_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, flush, out_ready, out_valid, all_done;
  logic [3:0]  src_en, src_valid, src_ready, src_done;
  logic [63:0] src_data;
  logic [15:0] out_data;
  logic [1:0]  out_src_id;
`ifdef GLB_ARB_STATS_EN
  logic [63:0] stat_count;
`endif

  glb_stream_arbiter #(.NUM_SRC(4), .DATA_W(16), .MAX_BURST(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .src_en     (src_en),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_done   (src_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src_id (out_src_id),
`ifdef GLB_ARB_STATS_EN
    .stat_count (stat_count),
`endif
    .all_done   (all_done)
  );

  always #5 clk = ~clk;

  logic [15:0] sq    [4][$];
  logic [15:0] exp_q [4][$];
  int          n_chk = 0, n_pass = 0;
  logic        xf, s_valid;
  logic [3:0]  s_rdy;
  logic [15:0] s_data;
  logic [1:0]  s_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, want);
  endtask

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      src_valid[i]         = (sq[i].size() != 0);
      src_data[i*16 +: 16] = (sq[i].size() != 0) ? sq[i][0] : 16'h0;
    end
  endtask

  task automatic push(input int i, input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) begin
      sq[i].push_back(base + 16'(k));
      exp_q[i].push_back(base + 16'(k));
    end
    drive_src();
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      sq[i].delete();
      exp_q[i].delete();
    end
    drive_src();
  endtask

  // Sample mid-cycle, score any transfer, then retire accepted words after the edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    s_valid = out_valid;
    s_rdy   = src_ready;
    s_data  = out_data;
    s_id    = out_src_id;
    xf      = out_valid && out_ready;
    if (xf) begin
      if (exp_q[s_id].size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        e = exp_q[s_id].pop_front();
        chk("data", 32'(s_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (s_rdy[i] && src_valid[i] && sq[i].size() != 0) void'(sq[i].pop_front());
    drive_src();
  endtask

  task automatic wait_xf(output logic [1:0] id);
    id = 2'd0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (xf) begin
        id = s_id;
        return;
      end
    end
    chk("wait_xf_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, n3;
    logic [1:0] id;
    rst_n = 1'b0; flush = 1'b0; src_en = '0; src_done = '0; out_ready = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_id",    32'(out_src_id), 32'd0);
    chk("rst_done",  32'(all_done),  32'd0);

    // All sources disabled: all_done on the second clock after release
    rst_n = 1'b1;
    step(); chk("t6_done_clk1", 32'(all_done), 32'd0);
    step(); chk("t6_done_clk2", 32'(all_done), 32'd1);
    chk("t6_valid", 32'(s_valid), 32'd0);
`ifdef GLB_ARB_STATS_EN
    chk("t6_stat_zero", 32'(stat_count == '0), 32'd1);
`endif

    // Single source streaming five words
    flush = 1'b1; src_en = 4'b0010; step(); flush = 1'b0;
    chk("t1_flush_done", 32'(all_done), 32'd0);
    push(1, 5, 16'h000A);
    step(); chk("t1_bubble", 32'(xf), 32'd0);
    for (int t = 0; t < 5; t++) begin
      step();
      chk("t1_xf", 32'(xf), 32'd1);
      chk("t1_id", 32'(s_id), 32'd1);
    end
    src_done = 4'b0010; step(); src_done = '0;
    step(); chk("t1_done_early", 32'(all_done), 32'd0);
    step(); chk("t1_done", 32'(all_done), 32'd1);
`ifdef GLB_ARB_STATS_EN
    chk("t1_stat", 32'(stat_count[31:16]), 32'd5);
`endif

    // Round-robin fairness with full bursts
    flush = 1'b1; clr(); src_en = 4'hF; step(); flush = 1'b0;
    for (int i = 0; i < 4; i++) push(i, 40, 16'((i + 1) * 16'h1000));
    for (int b = 0; b < 5; b++) begin
      step(); chk("t2_gap", 32'(xf), 32'd0);
      for (int t = 0; t < 8; t++) begin
        step();
        chk("t2_xf", 32'(xf), 32'd1);
        chk("t2_id", 32'(s_id), 32'((b + 1) % 4));
      end
    end
    step(); chk("t2_gap_end", 32'(xf), 32'd0);

    // Backpressure on source 2
    flush = 1'b1; clr(); src_en = 4'b0100; step(); flush = 1'b0;
    push(2, 12, 16'h2000);
    step(); chk("t3_bubble", 32'(xf), 32'd0);
    for (int p = 0; p < 4; p++) begin
      out_ready = (p % 2 == 0);
      step();
      chk("t3_rdy", 32'(s_rdy[2]), 32'(out_ready));
      chk("t3_xf", 32'(xf), 32'(out_ready));
      if (!out_ready) chk("t3_hold", 32'(s_data), 32'(exp_q[2][0]));
    end
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!xf) break;
      n++;
    end
    chk("t3_rest", 32'(n), 32'd6);

    // Done coincident with a transfer
    flush = 1'b1; clr(); src_en = 4'b1001; step(); flush = 1'b0;
    push(3, 10, 16'h3000); push(0, 2, 16'h0100);
    step(); chk("t4_bubble", 32'(xf), 32'd0);
    for (int t = 0; t < 3; t++) begin
      step(); chk("t4_id", 32'(s_id), 32'd3);
    end
    src_done = 4'b1000; step(); src_done = '0;
    chk("t4_done_xf", 32'(xf), 32'd1);
    chk("t4_done_id", 32'(s_id), 32'd3);
    step(); chk("t4_release", 32'(xf), 32'd0);
    n0 = 0; n3 = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (xf && s_id == 2'd0) n0++;
      if (xf && s_id == 2'd3) n3++;
    end
    chk("t4_src0", 32'(n0), 32'd2);
    chk("t4_src3_none", 32'(n3), 32'd0);
    chk("t4_not_done", 32'(all_done), 32'd0);

    // Flush mid-burst of source 0
    flush = 1'b1; clr(); src_en = 4'b0001; step(); flush = 1'b0;
    push(0, 10, 16'h5000);
    step(); chk("t5_bubble", 32'(xf), 32'd0);
    for (int t = 0; t < 4; t++) begin
      step(); chk("t5_id", 32'(s_id), 32'd0);
    end
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_flush_vld", 32'(s_valid), 32'd0);
    chk("t5_flush_rdy", 32'(s_rdy), 32'd0);
    src_en = 4'hF;
    push(1, 2, 16'h5100); push(3, 2, 16'h5300);
    wait_xf(id); chk("t5_first", 32'(id), 32'd1);
    wait_xf(id); chk("t5_second", 32'(id), 32'd1);
    wait_xf(id); chk("t5_src3", 32'(id), 32'd3);

    // Asynchronous reset in the middle of source 3's burst
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(src_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
